// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg
//   Shared constants for the iterative multiply/divide unit: default operand
//   width, mdOP operation encodings and FSM state encodings.
package mult_div_unit_pkg;

    localparam int MD_WIDTH = 32;

    // mdOP encodings; bit 1 selects divide, the MULT/DIV codes are the signed forms.
    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_ADJUST = 2'b10;

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative 32-cycle multiply/divide unit with one shared shift datapath.
//   Signed ops run on magnitudes; signs are fixed up in the ADJUST cycle.
//   Fixed latency of 33 cycles from the accepting edge to the done pulse.
//
//   state  | meaning
//   IDLE   | waiting for start; hi/lo/divByZero hold the last result
//   RUN    | one multiplier/quotient bit per cycle, counter 0..31
//   ADJUST | sign correction / divide-by-zero override, result commit
//
// Ports
//   clk, resetN          clock, asynchronous active-low reset
//   start                request, accepted only when busy=0
//   operand1, operand2   multiplicand/dividend, multiplier/divisor
//   mdOP                 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   busy                 operation in progress
//   done                 one-cycle pulse, results valid
//   hi, lo               product upper/lower half, or remainder/quotient
//   divByZero            last divide had operand2 = 0
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             start,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [1:0]       mdOP,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divByZero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int ACC_W = 2 * WIDTH + 1;

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [ACC_W-1:0] acc_q,     acc_d;
    logic [WIDTH-1:0] opb_q,     opb_d;
    logic [WIDTH-1:0] op1_q,     op1_d;
    logic             is_div_q,  is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_pend_q, dbz_pend_d;
    logic             done_q,    done_d;
    logic [WIDTH-1:0] hi_q,      hi_d;
    logic [WIDTH-1:0] lo_q,      lo_d;
    logic             dbz_q,     dbz_d;

    logic             sgn;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH:0]   mul_sum;
    logic [ACC_W-1:0] div_sh;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quot, rem;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        op1_d      = op1_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dbz_pend_d = dbz_pend_q;
        done_d     = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dbz_d      = dbz_q;

        sgn  = (mdOP == MD_MULT) || (mdOP == MD_DIV);
        mag1 = (sgn && operand1[WIDTH-1]) ? (~operand1 + 1'b1) : operand1;
        mag2 = (sgn && operand2[WIDTH-1]) ? (~operand2 + 1'b1) : operand2;

        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
        mul_sum = acc_q[ACC_W-1:WIDTH] + (acc_q[0] ? {1'b0, opb_q} : '0);
        // Divide: shift {remainder, dividend} left, bringing in the next dividend bit.
        div_sh  = {acc_q[ACC_W-2:0], 1'b0};

        prod = acc_q[2*WIDTH-1:0];
        quot = acc_q[WIDTH-1:0];
        rem  = acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    cnt_d      = '0;
                    is_div_d   = mdOP[1];
                    op1_d      = operand1;
                    neg_res_d  = sgn && (operand1[WIDTH-1] ^ operand2[WIDTH-1]);
                    neg_rem_d  = sgn && operand1[WIDTH-1];
                    dbz_pend_d = mdOP[1] && (operand2 == '0);
                    // Accumulator low half holds the value consumed bit by bit;
                    // opb is the value added (multiplicand) or subtracted (divisor).
                    if (mdOP[1]) begin
                        opb_d = mag2;
                        acc_d = {{(WIDTH + 1){1'b0}}, mag1};
                    end else begin
                        opb_d = mag1;
                        acc_d = {{(WIDTH + 1){1'b0}}, mag2};
                    end
                end
            end
            ST_RUN: begin
                if (is_div_q) begin
                    if (div_sh[ACC_W-1:WIDTH] >= {1'b0, opb_q})
                        acc_d = {div_sh[ACC_W-1:WIDTH] - {1'b0, opb_q},
                                 div_sh[WIDTH-1:1], 1'b1};
                    else
                        acc_d = div_sh;
                end else begin
                    acc_d = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1))
                    state_d = ST_ADJUST;
            end
            ST_ADJUST: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                dbz_d   = dbz_pend_q;
                if (!is_div_q) begin
                    if (neg_res_q)
                        prod = ~prod + 1'b1;
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (dbz_pend_q) begin
                    hi_d = op1_q;
                    lo_d = '1;
                end else begin
                    hi_d = neg_rem_q ? (~rem + 1'b1) : rem;
                    lo_d = neg_res_q ? (~quot + 1'b1) : quot;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            op1_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            op1_q      <= op1_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dbz_pend_q <= dbz_pend_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dbz_q      <= dbz_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign divByZero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Directed self-checking bench for mult_div_unit: one task per scenario,
//   expected values computed by hand.
module tb_mult_div_unit;

    logic        clk;
    logic        resetN;
    logic        start;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [1:0]  mdOP;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        divByZero;

    int n_tests = 0;
    int n_fail  = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .resetN    (resetN),
        .start     (start),
        .operand1  (operand1),
        .operand2  (operand2),
        .mdOP      (mdOP),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .divByZero (divByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op and wait (bounded) for done; returns the number of edges
    // from the accepting edge to the done pulse, or -1 on timeout. Returns
    // sampled inside the done cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat);
        @(negedge clk);
        mdOP = op; operand1 = a; operand2 = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0; start = 1'b0; mdOP = 2'b00; operand1 = '0; operand2 = '0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || divByZero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h dbz=%b, want all zero",
                     busy, done, hi, lo, divByZero);
        end
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic test_multu();
        int lat;
        run_op(2'b00, 32'd3, 32'd2, lat);
        n_tests++;
        if (lat !== 33 || hi !== 32'h0 || lo !== 32'h6 || divByZero !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL multu_3x2: lat=%0d hi=%h lo=%h dbz=%b busy=%b, want 33 0 6 0 0",
                     lat, hi, lo, divByZero, busy);
        end
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (done !== 1'b0 || lo !== 32'h6 || hi !== 32'h0) begin
            n_fail++;
            $display("FAIL multu_hold: done=%b hi=%h lo=%h, want 0 0 6", done, hi, lo);
        end
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        n_tests++;
        if (lat !== 33 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            n_fail++;
            $display("FAIL multu_max: lat=%0d hi=%h lo=%h, want 33 fffffffe 00000001", lat, hi, lo);
        end
    endtask

    task automatic test_mult();
        int lat;
        run_op(2'b01, 32'hFFFFFFFD, 32'd2, lat);
        n_tests++;
        if (lat !== 33 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
            n_fail++;
            $display("FAIL mult_neg3x2: lat=%0d hi=%h lo=%h, want 33 ffffffff fffffffa", lat, hi, lo);
        end
        run_op(2'b01, 32'hFFFFFFFD, 32'hFFFFFFFE, lat);
        n_tests++;
        if (lat !== 33 || hi !== 32'h0 || lo !== 32'h6) begin
            n_fail++;
            $display("FAIL mult_neg3xneg2: lat=%0d hi=%h lo=%h, want 33 0 6", lat, hi, lo);
        end
    endtask

    task automatic test_divu();
        int lat;
        run_op(2'b10, 32'd15, 32'd4, lat);
        n_tests++;
        if (lat !== 33 || lo !== 32'd3 || hi !== 32'd3 || divByZero !== 1'b0) begin
            n_fail++;
            $display("FAIL divu_15_4: lat=%0d hi=%h lo=%h dbz=%b, want 33 3 3 0", lat, hi, lo, divByZero);
        end
        run_op(2'b10, 32'd15, 32'd0, lat);
        n_tests++;
        if (lat !== 33 || lo !== 32'hFFFFFFFF || hi !== 32'h0000000F || divByZero !== 1'b1) begin
            n_fail++;
            $display("FAIL divu_by_zero: lat=%0d hi=%h lo=%h dbz=%b, want 33 f ffffffff 1",
                     lat, hi, lo, divByZero);
        end
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (divByZero !== 1'b1) begin
            n_fail++;
            $display("FAIL dbz_hold: dbz=%b, want 1", divByZero);
        end
        run_op(2'b00, 32'd3, 32'd2, lat);
        n_tests++;
        if (lat !== 33 || divByZero !== 1'b0 || lo !== 32'h6) begin
            n_fail++;
            $display("FAIL dbz_clear: lat=%0d dbz=%b lo=%h, want 33 0 6", lat, divByZero, lo);
        end
    endtask

    task automatic test_div();
        int lat;
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, lat);
        n_tests++;
        if (lat !== 33 || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF || divByZero !== 1'b0) begin
            n_fail++;
            $display("FAIL div_neg7_2: lat=%0d hi=%h lo=%h dbz=%b, want 33 ffffffff fffffffd 0",
                     lat, hi, lo, divByZero);
        end
        run_op(2'b11, 32'd7, 32'hFFFFFFFE, lat);
        n_tests++;
        if (lat !== 33 || lo !== 32'hFFFFFFFD || hi !== 32'h00000001) begin
            n_fail++;
            $display("FAIL div_7_neg2: lat=%0d hi=%h lo=%h, want 33 1 fffffffd", lat, hi, lo);
        end
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, lat);
        n_tests++;
        if (lat !== 33 || lo !== 32'h80000000 || hi !== 32'h0 || divByZero !== 1'b0) begin
            n_fail++;
            $display("FAIL div_overflow: lat=%0d hi=%h lo=%h dbz=%b, want 33 0 80000000 0",
                     lat, hi, lo, divByZero);
        end
        run_op(2'b11, 32'hFFFFFFF9, 32'd0, lat);
        n_tests++;
        if (lat !== 33 || lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFF9 || divByZero !== 1'b1) begin
            n_fail++;
            $display("FAIL div_by_zero: lat=%0d hi=%h lo=%h dbz=%b, want 33 fffffff9 ffffffff 1",
                     lat, hi, lo, divByZero);
        end
    endtask

    task automatic test_ignore_busy();
        int ndone = 0;
        int lat = -1;
        logic [31:0] lo_s = '0;
        @(negedge clk);
        mdOP = 2'b00; operand1 = 32'd5; operand2 = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_accept: busy=%b, want 1", busy);
        end
        for (int i = 1; i <= 45; i++) begin
            if (i == 10) begin
                start = 1'b1; operand1 = 32'd7; operand2 = 32'd7;
            end
            @(posedge clk);
            #1 start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    lat = i;
                    lo_s = lo;
                end
            end
        end
        n_tests++;
        if (ndone !== 1 || lat !== 33 || lo_s !== 32'd25) begin
            n_fail++;
            $display("FAIL ignore_busy: dones=%0d lat=%0d lo=%h, want 1 33 19", ndone, lat, lo_s);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(2'b00, 32'd5, 32'd5, lat);
        // Still inside the done cycle: request the next op right away.
        mdOP = 2'b00; operand1 = 32'd6; operand2 = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b done=%b, want 1 0", busy, done);
        end
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        n_tests++;
        if (lat !== 33 || lo !== 32'd42 || hi !== 32'h0) begin
            n_fail++;
            $display("FAIL b2b_result: lat=%0d hi=%h lo=%h, want 33 0 2a", lat, hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        int lat;
        @(negedge clk);
        mdOP = 2'b10; operand1 = 32'd100; operand2 = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", busy, done, hi, lo);
        end
        start = 1'b1; mdOP = 2'b00; operand1 = 32'd9; operand2 = 32'd9;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_reset: busy=%b, want 0", busy);
        end
        @(negedge clk);
        resetN = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        n_tests++;
        if (ndone !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done: dones=%0d busy=%b, want 0 0", ndone, busy);
        end
        run_op(2'b00, 32'd3, 32'd2, lat);
        n_tests++;
        if (lat !== 33 || lo !== 32'h6 || hi !== 32'h0) begin
            n_fail++;
            $display("FAIL after_reset_multu: lat=%0d hi=%h lo=%h, want 33 0 6", lat, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_divu();
        test_div();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
